// File: rtl/usb_pkt_rx_pkg.sv
// usb_pkt_rx_pkg: PID codes, report types, FSM states and CRC constants for the serial USB receiver
package usb_pkt_rx_pkg;
    localparam logic [7:0] SYNC = 8'h01;
    localparam logic [7:0] PID_OUT = 8'h87;
    localparam logic [7:0] PID_IN = 8'h96;
    localparam logic [7:0] PID_DATA = 8'hC3;
    localparam logic [7:0] PID_ACK = 8'h4B;
    localparam logic [7:0] PID_NAK = 8'h5A;
    localparam logic [1:0] TYPE_NON = 2'd0;
    localparam logic [1:0] TYPE_TOK = 2'd1;
    localparam logic [1:0] TYPE_DATA = 2'd2;
    localparam logic [1:0] TYPE_HS = 2'd3;
    localparam int TIMEOUT_LEN = 255;
    localparam logic [4:0] CRC5_POLY = 5'h05;
    localparam logic [4:0] CRC5_INIT = 5'h1f;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hffff;
    typedef enum logic [2:0] {HUNT, PID, TOKEN, DATA, REPORT} state_t;
    function automatic logic pid_good(input logic [7:0] p);
        return (p[7:4] == ~p[3:0]) && (p inside {PID_OUT, PID_IN, PID_DATA, PID_ACK, PID_NAK});
    endfunction
endpackage

// File: rtl/usb_pkt_rx_crc_lfsr.sv
// rx_crc_lfsr: serial CRC LFSR, MSB-first feedback, synchronous reload to INIT
module rx_crc_lfsr #(
    parameter int WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY = '0,
    parameter logic [WIDTH-1:0] INIT = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] lfsr
);
    logic fb;
    assign fb = bit_in ^ lfsr[WIDTH-1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= INIT;
        else if (clr) lfsr <= INIT;
        else if (en) lfsr <= {lfsr[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
endmodule

// File: rtl/usb_pkt_rx.sv
// usb_pkt_rx: serial USB packet decoder -- SYNC hunt, PID check, token/data capture,
// CRC5/CRC16 verification and a one-cycle registered packet report
module usb_pkt_rx
    import usb_pkt_rx_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_LEN,
    parameter int DATA_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 busy,
    output logic                 pkt_valid,
    output logic [1:0]           pkt_type,
    output logic [7:0]           pid,
    output logic [6:0]           addr,
    output logic [3:0]           endp,
    output logic [DATA_BITS-1:0] data,
    output logic                 crc_ok,
    output logic                 pid_err,
    output logic                 timeout
);
    localparam logic [6:0] PID_LAST = 7'd7;
    localparam logic [6:0] TOK_FIELD = 7'd11;
    localparam logic [6:0] TOK_LAST = 7'd15;
    localparam logic [6:0] DATA_FIELD = 7'(DATA_BITS);
    localparam logic [6:0] DATA_LAST = 7'(DATA_BITS + 15);
    localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);

    state_t state, nxt;
    logic [6:0] cnt;
    logic [7:0] gap, win, pid_sh, win_nx, pid_nx;
    logic [DATA_BITS-1:0] sr;
    logic [15:0] crc_sh, crc_nx, crc16;
    logic [4:0] crc5;
    logic in_pkt, gap_hit, pay_en, crc_en, crc_clr, rep_load;
    logic [1:0] r_type;
    logic r_crc, r_perr, r_to;

    assign win_nx = {win[6:0], bit_in};
    assign pid_nx = {pid_sh[6:0], bit_in};
    assign crc_nx = {crc_sh[14:0], bit_in};
    assign in_pkt = state inside {PID, TOKEN, DATA};
    assign gap_hit = in_pkt && !bit_valid && gap == GAP_LAST;
    assign pay_en = bit_valid && ((state == TOKEN && cnt < TOK_FIELD) || (state == DATA && cnt < DATA_FIELD));
    assign crc_en = bit_valid && ((state == TOKEN && cnt >= TOK_FIELD) || (state == DATA && cnt >= DATA_FIELD));
    assign crc_clr = state == HUNT && nxt == PID;
    assign rep_load = nxt == REPORT && state != REPORT;

    rx_crc_lfsr #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk(clk), .rst(rst), .clr(crc_clr), .en(pay_en && state == TOKEN), .bit_in(bit_in), .lfsr(crc5)
    );
    rx_crc_lfsr #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk(clk), .rst(rst), .clr(crc_clr), .en(pay_en && state == DATA), .bit_in(bit_in), .lfsr(crc16)
    );

    always_comb begin
        nxt = state;
        r_type = TYPE_NON;
        r_crc = 1'b0;
        r_perr = 1'b0;
        r_to = 1'b0;
        case (state)
            HUNT: nxt = (bit_valid && win_nx == SYNC) ? PID : HUNT;
            PID: if (bit_valid && cnt == PID_LAST) begin
                r_perr = !pid_good(pid_nx);
                r_type = r_perr ? TYPE_NON : TYPE_HS;
                r_crc = !r_perr;
                nxt = r_perr ? REPORT : (pid_nx inside {PID_OUT, PID_IN}) ? TOKEN : pid_nx == PID_DATA ? DATA : REPORT;
            end
            TOKEN: if (bit_valid && cnt == TOK_LAST) begin
                nxt = REPORT;
                r_type = TYPE_TOK;
                r_crc = crc_nx[4:0] == ~crc5;
            end
            DATA: if (bit_valid && cnt == DATA_LAST) begin
                nxt = REPORT;
                r_type = TYPE_DATA;
                r_crc = crc_nx == ~crc16;
            end
            default: nxt = HUNT;
        endcase
        // a stalled packet overrides whatever field was in progress
        if (gap_hit) begin
            nxt = REPORT;
            r_type = TYPE_NON;
            r_crc = 1'b0;
            r_perr = 1'b0;
            r_to = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            cnt <= '0;
            gap <= '0;
            win <= '0;
            pid_sh <= '0;
            sr <= '0;
            crc_sh <= '0;
            busy <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_type <= TYPE_NON;
            pid <= '0;
            addr <= '0;
            endp <= '0;
            data <= '0;
            crc_ok <= 1'b0;
            pid_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= (nxt != state) ? '0 : (in_pkt && bit_valid) ? cnt + 7'd1 : cnt;
            gap <= (in_pkt && !bit_valid) ? gap + 8'd1 : '0;
            win <= (state == REPORT) ? '0 : (state == HUNT && bit_valid) ? win_nx : win;
            if (state == PID && bit_valid) pid_sh <= pid_nx;
            if (pay_en) sr <= {sr[DATA_BITS-2:0], bit_in};
            if (crc_en) crc_sh <= crc_nx;
            busy <= nxt inside {PID, TOKEN, DATA};
            pkt_valid <= rep_load;
            if (rep_load) begin
                pkt_type <= r_type;
                pid <= (state == PID && bit_valid) ? pid_nx : pid_sh;
                addr <= (r_type == TYPE_TOK) ? sr[10:4] : '0;
                endp <= (r_type == TYPE_TOK) ? sr[3:0] : '0;
                data <= (r_type == TYPE_DATA) ? sr : '0;
                crc_ok <= r_crc;
                pid_err <= r_perr;
                timeout <= r_to;
            end
        end
    end
endmodule

// File: tb/tb_usb_pkt_rx.sv
// tb_usb_pkt_rx: scoreboard bench for usb_pkt_rx; expected reports are queued
// as packets are sent and compared when pkt_valid fires
module tb_usb_pkt_rx;
    import usb_pkt_rx_pkg::*;

    typedef struct {
        logic [1:0] t;
        logic [7:0] p;
        logic [6:0] a;
        logic [3:0] e;
        logic [63:0] d;
        logic c;
        logic pe;
        logic to;
    } rep_t;

    logic clk = 1'b0;
    logic rst, bit_in, bit_valid;
    logic busy, pkt_valid, crc_ok, pid_err, timeout;
    logic [1:0] pkt_type;
    logic [7:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic [63:0] data;
    rep_t exp_q[$];
    rep_t mon;
    int checks = 0;
    int errors = 0;

    usb_pkt_rx #(.TIMEOUT(255), .DATA_BITS(64)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy),
        .pkt_valid(pkt_valid), .pkt_type(pkt_type), .pid(pid), .addr(addr), .endp(endp),
        .data(data), .crc_ok(crc_ok), .pid_err(pid_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gold_crc5(input logic [10:0] d);
        logic [4:0] r = 5'h1f;
        for (int i = 10; i >= 0; i--) r = (d[i] ^ r[4]) ? ({r[3:0], 1'b0} ^ 5'h05) : {r[3:0], 1'b0};
        return ~r;
    endfunction

    function automatic logic [15:0] gold_crc16(input logic [63:0] d);
        logic [15:0] r = 16'hffff;
        for (int i = 63; i >= 0; i--) r = (d[i] ^ r[15]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
        return ~r;
    endfunction

    task automatic send(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in = v[i];
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
    endtask

    // reports are compared away from the active edge
    always @(negedge clk) begin
        if (pkt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_report: got pkt_type=%0d pid=%h, expected no report", pkt_type, pid);
            end else begin
                mon = exp_q.pop_front();
                checks++;
                if (pkt_type !== mon.t) begin errors++; $display("FAIL pkt_type: got %0d expected %0d", pkt_type, mon.t); end
                checks++;
                if (pid !== mon.p) begin errors++; $display("FAIL pid: got %h expected %h", pid, mon.p); end
                checks++;
                if (pid_err !== mon.pe) begin errors++; $display("FAIL pid_err: got %b expected %b", pid_err, mon.pe); end
                checks++;
                if (timeout !== mon.to) begin errors++; $display("FAIL timeout: got %b expected %b", timeout, mon.to); end
                if (!mon.pe) begin
                    checks++;
                    if (crc_ok !== mon.c) begin errors++; $display("FAIL crc_ok: got %b expected %b (pid %h)", crc_ok, mon.c, mon.p); end
                end
                if (mon.t == TYPE_TOK) begin
                    checks++;
                    if (addr !== mon.a) begin errors++; $display("FAIL addr: got %h expected %h", addr, mon.a); end
                    checks++;
                    if (endp !== mon.e) begin errors++; $display("FAIL endp: got %h expected %h", endp, mon.e); end
                end
                if (mon.t == TYPE_DATA) begin
                    checks++;
                    if (data !== mon.d) begin errors++; $display("FAIL data: got %h expected %h", data, mon.d); end
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pkt_valid, busy, pkt_type, pid, addr, endp, crc_ok, pid_err, timeout} !== '0 || data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got pkt_valid=%b busy=%b pid=%h data=%h, expected all 0", pkt_valid, busy, pid, data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({pkt_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: got pkt_valid=%b busy=%b expected 0 0", pkt_valid, busy); end
    endtask

    task automatic test_ack(input logic [7:0] p);
        exp_q.push_back('{TYPE_HS, p, 7'h0, 4'h0, 64'h0, 1'b1, 1'b0, 1'b0});
        send({8'h01, p}, 16);
        checks++;
        if (pkt_valid !== 1'b1) begin errors++; $display("FAIL hs_latency: pkt_valid=%b expected 1", pkt_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (pkt_valid !== 1'b0) begin errors++; $display("FAIL hs_one_cycle: pkt_valid=%b expected 0", pkt_valid); end
    endtask

    task automatic test_token(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e, input logic [4:0] flip);
        logic [4:0] c;
        c = gold_crc5({a, e}) ^ flip;
        exp_q.push_back('{TYPE_TOK, p, a, e, 64'h0, flip == 5'd0, 1'b0, 1'b0});
        send({8'h01, p}, 16);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL tok_busy: busy=%b expected 1", busy); end
        send({a, e, c}, 16);
        checks++;
        if (pkt_valid !== 1'b1) begin errors++; $display("FAIL tok_latency: pkt_valid=%b expected 1", pkt_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_data(input logic [63:0] pay, input logic [63:0] flip);
        logic [15:0] c;
        c = gold_crc16(pay);
        exp_q.push_back('{TYPE_DATA, PID_DATA, 7'h0, 4'h0, pay ^ flip, flip == 64'd0, 1'b0, 1'b0});
        send({8'h01, PID_DATA, pay ^ flip, c}, 96);
        checks++;
        if (pkt_valid !== 1'b1) begin errors++; $display("FAIL data_latency: pkt_valid=%b expected 1", pkt_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bad_pid(input logic [7:0] p);
        exp_q.push_back('{TYPE_NON, p, 7'h0, 4'h0, 64'h0, 1'b0, 1'b1, 1'b0});
        send({8'h01, p}, 16);
        checks++;
        if (pkt_valid !== 1'b1) begin errors++; $display("FAIL badpid_latency: pkt_valid=%b expected 1", pkt_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL badpid_no_fields: busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout;
        int n = 0;
        exp_q.push_back('{TYPE_NON, PID_DATA, 7'h0, 4'h0, 64'h0, 1'b0, 1'b0, 1'b1});
        send({8'h01, PID_DATA, 10'h2A5}, 26);
        while (pkt_valid !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 255) begin errors++; $display("FAIL timeout_gap: report after %0d idle cycles expected 255", n); end
    endtask

    task automatic test_back_to_back;
        test_timeout();
        test_ack(PID_ACK);
    endtask

    task automatic test_rst_mid;
        send({8'h01, PID_DATA, 40'hA5_5A_F0_0F_C3}, 56);
        rst = 1'b1;
        #1;
        checks++;
        if ({pkt_valid, busy, pkt_type, pid, addr, endp, crc_ok, pid_err, timeout} !== '0 || data !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got pkt_valid=%b busy=%b pid=%h data=%h, expected all 0", pkt_valid, busy, pid, data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_token(PID_OUT, 7'b1010000, 4'b0010, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ack(PID_ACK);
        test_ack(PID_NAK);
        test_token(PID_OUT, 7'b1010000, 4'b0010, 5'd0);
        test_token(PID_OUT, 7'b1010000, 4'b0010, 5'b00100);
        test_token(PID_IN, 7'h7F, 4'hF, 5'd0);
        test_data(64'hDEADBEEF01234567, 64'd0);
        test_data(64'hDEADBEEF01234567, 64'd1);
        test_bad_pid(8'h88);
        test_bad_pid(8'hE1);
        test_back_to_back();
        test_rst_mid();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL missing_reports: %0d pending expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
